aes128_cbc_stream: RTL

//  Streaming AES-128 encryptor: iterative one-round-per-cycle core with on-the-fly key expansion.

---
 rtl/aes128_pkg.sv | 60 ++++++
 rtl/aes128_round_unit.sv | 52 +++++
 rtl/aes128_cbc_stream.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/aes128_pkg.sv
// Shared AES-128 constants, S-box/key-schedule helpers, FSM state and FIFO entry types.
package aes128_pkg;

  localparam int AES_BLK_W  = 128;
  localparam int NUM_ROUNDS = 10;

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} fsm_e;

  typedef struct packed {
    logic                 last;
    logic [AES_BLK_W-1:0] data;
  } out_ent_t;

  // Forward S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes128_round_unit.sv
// One combinational AES-128 encryption round plus the matching round-key expansion step.
// Byte b of the state lives at bits [127-8b -: 8]; row = b%4, column = b/4.
module aes128_round_unit
  import aes128_pkg::*;
(
  input  logic [AES_BLK_W-1:0] state_in,
  input  logic [AES_BLK_W-1:0] rk_in,
  input  logic [3:0]           rnd,
  input  logic                 last_rnd,
  output logic [AES_BLK_W-1:0] state_out,
  output logic [AES_BLK_W-1:0] rk_next
);

  logic [31:0] w0, w1, w2, w3, tmp;
  logic [31:0] n0, n1, n2, n3;
  logic [AES_BLK_W-1:0] sr_w;
  logic [AES_BLK_W-1:0] mc_w;

  assign w0  = rk_in[127:96];
  assign w1  = rk_in[95:64];
  assign w2  = rk_in[63:32];
  assign w3  = rk_in[31:0];
  assign tmp = sub_word(rot_word(w3)) ^ {rcon(rnd), 24'h000000};
  assign n0  = w0 ^ tmp;
  assign n1  = w1 ^ n0;
  assign n2  = w2 ^ n1;
  assign n3  = w3 ^ n2;
  assign rk_next = {n0, n1, n2, n3};

  // SubBytes fused with ShiftRows: row r is rotated left by r columns.
  for (genvar b = 0; b < 16; b++) begin : g_sr
    localparam int R   = b % 4;
    localparam int C   = b / 4;
    localparam int SRC = R + 4 * ((C + R) % 4);
    assign sr_w[127-8*b -: 8] = sbox(state_in[127-8*SRC -: 8]);
  end

  for (genvar c = 0; c < 4; c++) begin : g_mc
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr_w[127-8*(4*c+0) -: 8];
    assign a1 = sr_w[127-8*(4*c+1) -: 8];
    assign a2 = sr_w[127-8*(4*c+2) -: 8];
    assign a3 = sr_w[127-8*(4*c+3) -: 8];
    assign mc_w[127-8*(4*c+0) -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mc_w[127-8*(4*c+1) -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mc_w[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mc_w[127-8*(4*c+3) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  assign state_out = (last_rnd ? sr_w : mc_w) ^ rk_next;

endmodule

// File: rtl/aes128_cbc_stream.sv
// Streaming AES-128 CBC/ECB encryptor, one round per cycle, 12 cycles accept-to-out_valid.
// Accepts only in IDLE with a free output slot, so a block in flight can always retire.
module aes128_cbc_stream
  import aes128_pkg::*;
#(
  parameter int CBC_EN    = 1,
  parameter int OUT_DEPTH = 2,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [AES_BLK_W-1:0] key,
  input  logic [AES_BLK_W-1:0] iv,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] in_data,
  input  logic                 in_first,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] out_data,
  output logic                 out_last,
  output logic [CNT_W-1:0]     blk_count,
  output logic                 busy
);

  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(OUT_DEPTH);
  localparam logic [3:0]    LAST_RND = 4'(NUM_ROUNDS);

  fsm_e                 fsm_q, fsm_d;
  logic [AES_BLK_W-1:0] state_q, state_d;
  logic [AES_BLK_W-1:0] rk_q, rk_d;
  logic [AES_BLK_W-1:0] base_key_q, base_key_d;
  logic [AES_BLK_W-1:0] chain_q, chain_d;
  logic [3:0]           rnd_q, rnd_d;
  logic                 first_q, first_d;
  logic                 last_q, last_d;
  logic [CNT_W-1:0]     blk_count_q, blk_count_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        fifo_cnt_q, fifo_cnt_d;
  out_ent_t             fifo_mem_q [OUT_DEPTH];
  out_ent_t             fifo_mem_d [OUT_DEPTH];

  logic [AES_BLK_W-1:0] rnd_state, rnd_key, chain_mask;
  logic                 push, pop;
  out_ent_t             head;

  aes128_round_unit u_round (
    .state_in  (state_q),
    .rk_in     (rk_q),
    .rnd       (rnd_q),
    .last_rnd  (rnd_q == LAST_RND),
    .state_out (rnd_state),
    .rk_next   (rnd_key)
  );

  assign head       = fifo_mem_q[rd_ptr_q];
  assign out_valid  = (fifo_cnt_q != '0);
  assign out_data   = head.data;
  assign out_last   = head.last;
  assign in_ready   = (fsm_q == IDLE) && (fifo_cnt_q < DEPTH_C);
  assign busy       = (fsm_q != IDLE) || out_valid;
  assign blk_count  = blk_count_q;
  assign pop        = out_valid && out_ready;
  assign chain_mask = (CBC_EN != 0) ? chain_q : '0;

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    rk_d        = rk_q;
    base_key_d  = base_key_q;
    chain_d     = chain_q;
    rnd_d       = rnd_q;
    first_d     = first_q;
    last_d      = last_q;
    blk_count_d = blk_count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_cnt_d  = fifo_cnt_q;
    fifo_mem_d  = fifo_mem_q;
    push        = 1'b0;

    case (fsm_q)
      IDLE: begin
        // key/iv are only guaranteed on the accept cycle, so latch them here.
        if (in_valid && in_ready) begin
          state_d = in_data;
          first_d = in_first;
          last_d  = in_last;
          if (in_first) begin
            base_key_d = key;
            chain_d    = iv;
          end
          fsm_d = LOAD;
        end
      end
      LOAD: begin
        state_d = state_q ^ chain_mask ^ base_key_q;
        rk_d    = base_key_q;
        rnd_d   = 4'd1;
        fsm_d   = ROUND;
      end
      ROUND: begin
        state_d = rnd_state;
        rk_d    = rnd_key;
        rnd_d   = rnd_q + 4'd1;
        if (rnd_q == LAST_RND) begin
          fsm_d = DONE;
        end
      end
      DONE: begin
        push                 = 1'b1;
        fifo_mem_d[wr_ptr_q] = '{last: last_q, data: state_q};
        wr_ptr_d             = wr_ptr_q + PW'(1);
        chain_d              = state_q;
        rk_d                 = base_key_q;
        if (first_q) begin
          blk_count_d = CNT_W'(1);
        end else if (blk_count_q != '1) begin
          blk_count_d = blk_count_q + CNT_W'(1);
        end
        fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      rk_q        <= '0;
      base_key_q  <= '0;
      chain_q     <= '0;
      rnd_q       <= '0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      blk_count_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      rk_q        <= rk_d;
      base_key_q  <= base_key_d;
      chain_q     <= chain_d;
      rnd_q       <= rnd_d;
      first_q     <= first_d;
      last_q      <= last_d;
      blk_count_q <= blk_count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      fifo_mem_q  <= fifo_mem_d;
    end
  end

endmodule
